dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU MEM stage (port 0) and a debug/loader port (port 1).
//  - Round-robin arbitration; one access at a time.
//  - Sequences a fixed-latency memory and returns read data and an error flag per requester.
//  - Drives cpu_stall to freeze the pipeline while the CPU access is pending.
// PARAMETERS
//  ADDR_W      8   byte-address width on both requester ports
//  DEPTH_BYTES 32  implemented data memory size in bytes; word accesses at addr > DEPTH_BYTES-4 are errors
//  MEM_LAT     1   cycles from mem_en sampled to mem_rdata valid (>=1)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous reset, active-high
//  cpu_req    in   1       CPU access request; held high until cpu_ack
//  cpu_we     in   1       1=store word, 0=load word
//  cpu_addr   in   ADDR_W  byte address
//  cpu_wdata  in   32      store data
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_rdata  out  32      load data, valid with cpu_ack, held until next cpu_ack
//  cpu_err    out  1       misaligned or out-of-range access, valid with cpu_ack
//  cpu_stall  out  1       cpu_req & ~cpu_ack (combinational)
//  dbg_req/dbg_we/dbg_addr/dbg_wdata  in   same widths and meaning as the cpu_* inputs
//  dbg_ack/dbg_rdata/dbg_err          out  same widths and meaning as the cpu_* outputs
//  mem_en     out  1       memory access strobe, one cycle per access
//  mem_we     out  1       write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  word-aligned byte address to memory
//  mem_wdata  out  32      write data to memory
//  mem_rdata  in   32      read data, valid MEM_LAT cycles after mem_en
//  busy       out  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset values: all ack/err/mem_en/mem_we/busy = 0; rdata = 0; FSM = IDLE; last_gnt = dbg, so the CPU wins the first tie.
//  - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE; error path IDLE -> DONE.
//  - IDLE, arbitration:
//    - Only one req high: grant that port.
//    - Both high: grant the port != last_gnt.
//    - On grant: latch we/addr/wdata, update last_gnt.
//    - Aligned, in range: go to ISSUE.
//    - Misaligned (addr[1:0] != 0) or addr > DEPTH_BYTES-4: go to DONE with err=1 and no mem_en.
//  - ISSUE: mem_en=1 for exactly one cycle with the latched signals. Go to WAIT with cnt = MEM_LAT.
//  - WAIT: decrement cnt. On the cycle cnt==1, register mem_rdata into the granted port's rdata (reads only). Then go to DONE.
//  - DONE: ack=1 for the granted port only, err as determined. Go to IDLE.
//  - Latency: req seen in IDLE at cycle t -> ack at t+MEM_LAT+2. Error ack at t+1.
//  - Stores: rdata is unchanged and err=0 on ack.
//  - Other port's rdata/err are untouched.
//  - Requests arriving while busy wait.
//    - A req that drops before its ack is ignored if not yet granted.
//    - An already-granted access completes normally.
//  - Simultaneous DONE and a new req: the new req is only sampled in the following IDLE cycle, so there are no back-to-back grants without an IDLE cycle.
//  - Reset mid-access: abort immediately, with no ack and no further mem_en. A partially issued store is not rolled back.
//  - Fairness: with both ports continuously requesting, grants alternate cpu, dbg, cpu, ...
// STRUCTURE
//  - Shared package dmem_arb_pkg:
//    - FSM state encoding (IDLE, ISSUE, WAIT, DONE).
//    - Port index constants (PORT_CPU=0, PORT_DBG=1).
//    - Word size constant (4).
//  - Sub-module rr_arb2: 2-way round-robin grant logic with a last_gnt register, updated on grant.
//  - The FSM, latch registers and WAIT counter (width $clog2(MEM_LAT+1)) stay in dmem_arbiter.
// TESTING
//  1. CPU load only, MEM_LAT=1, addr 0x00, mem word 5:
//     mem_en at t+1, cpu_ack at t+3, cpu_rdata=5, cpu_stall high t..t+2.
//  2. Both request at the same cycle after reset, cpu store 0x11 @0x04, dbg load @0x04:
//     CPU granted first; dbg then reads 0x11. Ack order cpu then dbg.
//  3. Both requesting continuously for 6 accesses: grant order cpu,dbg,cpu,dbg,cpu,dbg.
//  4. dbg load @0x06, then @0x20 with DEPTH_BYTES=32:
//     dbg_ack at t+1 with dbg_err=1, no mem_en, dbg_rdata unchanged.
//  5. MEM_LAT=3, cpu load @0x08:
//     ack at t+5; mem_rdata sampled exactly once; mem_en high exactly one cycle.
//  6. rst asserted during WAIT of a dbg access:
//     no dbg_ack, busy=0 next cycle, next tie goes to CPU.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - arb_state_t : FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   - PORT_CPU / PORT_DBG : requester indices as seen by the grant logic
//   - WORD_BYTES : access size in bytes (all accesses are full words)
//   - addr_is_bad() : misaligned / out-of-range check for a requested address
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int PORT_CPU   = 0;
    localparam int PORT_DBG   = 1;
    localparam int WORD_BYTES = 4;

    // A word access is illegal when it is not word aligned or when its last
    // byte would fall beyond the implemented memory.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int depth_bytes);
        logic [31:0] last_ok;
        last_ok = 32'(depth_bytes - WORD_BYTES);
        return (addr[1:0] != 2'b00) || (addr > last_ok);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant logic.
//   clk, rst   : clock, synchronous active-high reset
//   req[1:0]   : request vector, bit index = port index
//   en         : arbitration window (grant only taken while en is high)
//   gnt_valid  : a grant is being issued this cycle
//   gnt_idx    : index of the granted port
// last_gnt resets to the debug port so the CPU wins the first tie.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_gnt_r;

    // Grant decision: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'(PORT_CPU);
        if (en) begin
            gnt_valid = |req;
            case (req)
                2'b11:   gnt_idx = ~last_gnt_r;
                2'b10:   gnt_idx = 1'(PORT_DBG);
                default: gnt_idx = 1'(PORT_CPU);
            endcase
        end else begin
            gnt_valid = 1'b0;
        end
    end

    // Remember which port was granted most recently.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_r <= 1'(PORT_DBG);
        end else if (gnt_valid) begin
            last_gnt_r <= gnt_idx;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, fixed-latency data memory between the
// CPU MEM stage (port 0) and a debug/loader port (port 1).
//   clk, rst                          : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata             : CPU request, held until cpu_ack
//   cpu_ack/rdata/err                 : completion pulse, load data (held), error flag
//   cpu_stall                         : cpu_req & ~cpu_ack
//   dbg_req/we/addr/wdata, dbg_ack/rdata/err : same as the CPU port
//   mem_en/we/addr/wdata              : one-cycle memory strobe and access fields
//   mem_rdata                         : read data, valid MEM_LAT cycles after mem_en
//   busy                              : FSM not in IDLE
// Handshake timing: request seen in IDLE at cycle t -> mem_en at t+1 ->
// ack at t+MEM_LAT+2; illegal addresses ack with err at t+1 without mem_en.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_BYTES = 32,
    parameter int MEM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t        state_r, state_s;
    logic              gnt_valid_s, gnt_idx_s;
    logic              gnt_r, we_r, acc_err_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              sel_we_s, bad_s, load_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic              port_s, acc_we_s, acc_err_s;

    logic              cpu_ack_r, dbg_ack_r, cpu_err_r, dbg_err_r;
    logic              mem_en_r, mem_we_r, busy_r;
    logic [31:0]       cpu_rdata_r, dbg_rdata_r;

    logic              cpu_ack_d, dbg_ack_d, mem_en_d, mem_we_d, busy_d;
    logic              rd_capture_s;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .req       ({dbg_req, cpu_req}),
        .en        (state_r == ST_IDLE),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Request fields of the port currently winning arbitration.
    always_comb begin
        if (gnt_idx_s == 1'(PORT_DBG)) begin
            sel_we_s    = dbg_we;
            sel_addr_s  = dbg_addr;
            sel_wdata_s = dbg_wdata;
        end else begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
        bad_s  = addr_is_bad(32'(sel_addr_s), DEPTH_BYTES);
        load_s = (state_r == ST_IDLE) && gnt_valid_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_s = bad_s ? ST_DONE : ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Latch the granted request so the requester may change its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r     <= 1'(PORT_CPU);
            we_r      <= 1'b0;
            acc_err_r <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= 32'h0000_0000;
        end else if (load_s) begin
            gnt_r     <= gnt_idx_s;
            we_r      <= sel_we_s;
            acc_err_r <= bad_s;
            addr_r    <= sel_addr_s;
            wdata_r   <= sel_wdata_s;
        end else begin
            gnt_r     <= gnt_r;
            we_r      <= we_r;
            acc_err_r <= acc_err_r;
            addr_r    <= addr_r;
            wdata_r   <= wdata_r;
        end
    end

    // Memory latency counter: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= CNT_W'(MEM_LAT);
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output decode for the next cycle. Fields come straight from the
    // arbitration inputs when the access is being granted this cycle,
    // otherwise from the latched copy.
    always_comb begin
        port_s       = load_s ? gnt_idx_s : gnt_r;
        acc_we_s     = load_s ? sel_we_s  : we_r;
        acc_err_s    = load_s ? bad_s     : acc_err_r;
        mem_en_d     = (state_s == ST_ISSUE);
        mem_we_d     = mem_en_d && acc_we_s;
        cpu_ack_d    = (state_s == ST_DONE) && (port_s == 1'(PORT_CPU));
        dbg_ack_d    = (state_s == ST_DONE) && (port_s == 1'(PORT_DBG));
        busy_d       = (state_s != ST_IDLE);
        rd_capture_s = (state_r == ST_WAIT) && (cnt_r == CNT_W'(1)) && !we_r;
    end

    // Registered outputs; err/rdata of the idle port are left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            cpu_ack_r   <= 1'b0;
            dbg_ack_r   <= 1'b0;
            busy_r      <= 1'b0;
            cpu_err_r   <= 1'b0;
            dbg_err_r   <= 1'b0;
            cpu_rdata_r <= 32'h0000_0000;
            dbg_rdata_r <= 32'h0000_0000;
        end else begin
            mem_en_r  <= mem_en_d;
            mem_we_r  <= mem_we_d;
            cpu_ack_r <= cpu_ack_d;
            dbg_ack_r <= dbg_ack_d;
            busy_r    <= busy_d;
            cpu_err_r <= cpu_ack_d ? acc_err_s : cpu_err_r;
            dbg_err_r <= dbg_ack_d ? acc_err_s : dbg_err_r;
            if (rd_capture_s && (gnt_r == 1'(PORT_CPU))) begin
                cpu_rdata_r <= mem_rdata;
            end else begin
                cpu_rdata_r <= cpu_rdata_r;
            end
            if (rd_capture_s && (gnt_r == 1'(PORT_DBG))) begin
                dbg_rdata_r <= mem_rdata;
            end else begin
                dbg_rdata_r <= dbg_rdata_r;
            end
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign cpu_ack   = cpu_ack_r;
    assign dbg_ack   = dbg_ack_r;
    assign cpu_err   = cpu_err_r;
    assign dbg_err   = dbg_err_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dbg_rdata = dbg_rdata_r;
    assign busy      = busy_r;
    assign cpu_stall = cpu_req && !cpu_ack_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: one instance with MEM_LAT=1 for the
// arbitration/error/reset scenarios and one with MEM_LAT=3 for latency.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // MEM_LAT = 1 instance
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0]  cpu_addr, dbg_addr, mem_addr;
    logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err, mem_en, mem_we, busy;

    // MEM_LAT = 3 instance
    logic        l3_cpu_req, l3_cpu_we, l3_dbg_req, l3_dbg_we;
    logic [7:0]  l3_cpu_addr, l3_dbg_addr, l3_mem_addr;
    logic [31:0] l3_cpu_wdata, l3_dbg_wdata, l3_cpu_rdata, l3_dbg_rdata, l3_mem_wdata, l3_mem_rdata;
    logic        l3_cpu_ack, l3_cpu_err, l3_cpu_stall, l3_dbg_ack, l3_dbg_err;
    logic        l3_mem_en, l3_mem_we, l3_busy;

    dmem_arbiter #(.ADDR_W(8), .DEPTH_BYTES(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(8), .DEPTH_BYTES(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(l3_cpu_req), .cpu_we(l3_cpu_we), .cpu_addr(l3_cpu_addr), .cpu_wdata(l3_cpu_wdata),
        .cpu_ack(l3_cpu_ack), .cpu_rdata(l3_cpu_rdata), .cpu_err(l3_cpu_err), .cpu_stall(l3_cpu_stall),
        .dbg_req(l3_dbg_req), .dbg_we(l3_dbg_we), .dbg_addr(l3_dbg_addr), .dbg_wdata(l3_dbg_wdata),
        .dbg_ack(l3_dbg_ack), .dbg_rdata(l3_dbg_rdata), .dbg_err(l3_dbg_err),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
        .mem_rdata(l3_mem_rdata), .busy(l3_busy)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h0000_0005 + 32'(i) * 32'h0000_0010;
    endfunction

    // Memory model, latency 1: data valid only in the cycle after mem_en.
    logic [31:0] mem1 [0:7];
    logic [31:0] rd1_r;
    logic        rv1_r;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem1[i] <= init_word(i);
            rd1_r <= 32'h0;
            rv1_r <= 1'b0;
        end else begin
            rv1_r <= mem_en & ~mem_we;
            if (mem_en) begin
                rd1_r <= mem1[mem_addr[4:2]];
                if (mem_we) mem1[mem_addr[4:2]] <= mem_wdata;
            end
        end
    end
    assign mem_rdata = rv1_r ? rd1_r : 32'hDEAD_BEEF;

    // Memory model, latency 3 (read-only use): data valid only 3 cycles after mem_en.
    logic [31:0] rd3_r [0:2];
    logic        rv3_r [0:2];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                rd3_r[i] <= 32'h0;
                rv3_r[i] <= 1'b0;
            end
        end else begin
            rd3_r[0] <= init_word(int'(l3_mem_addr[4:2]));
            rv3_r[0] <= l3_mem_en & ~l3_mem_we;
            rd3_r[1] <= rd3_r[0];
            rv3_r[1] <= rv3_r[0];
            rd3_r[2] <= rd3_r[1];
            rv3_r[2] <= rv3_r[1];
        end
    end
    assign l3_mem_rdata = rv3_r[2] ? rd3_r[2] : 32'hDEAD_BEEF;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: one entry per expected ack, in grant order.
    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t        sb_q[$];
    logic [31:0] ref_mem [0:7];
    logic [31:0] last_rd [0:1];

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
    endtask

    task automatic push(input int port, input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic bad;
        bad = (addr[1:0] != 2'b00) || (addr > 8'd28);
        if (!bad) begin
            if (we) ref_mem[addr[4:2]] = wdata;
            else    last_rd[port] = ref_mem[addr[4:2]];
        end
        e.port  = port;
        e.err   = bad;
        e.rdata = last_rd[port];
        sb_q.push_back(e);
    endtask

    // Ack monitor for the MEM_LAT=1 instance.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && (cpu_ack || dbg_ack)) begin
            chk("single_ack", 32'(cpu_ack & dbg_ack), 32'd0);
            chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("sb_port", dbg_ack ? 32'd1 : 32'd0, 32'(mon_e.port));
                chk("sb_rdata", dbg_ack ? dbg_rdata : cpu_rdata, mon_e.rdata);
                chk("sb_err", 32'(dbg_ack ? dbg_err : cpu_err), 32'(mon_e.err));
            end
        end
    end

    task automatic wait_ack(input int port, input int max_cyc);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < max_cyc) begin
            @(negedge clk);
            n++;
            seen = (port == 1) ? dbg_ack : cpu_ack;
        end
        chk($sformatf("ack_seen_p%0d", port), 32'(seen), 32'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        ref_reset();
    endtask

    int en_cnt, en_cyc, ack_cyc;

    initial begin
        rst = 1'b1;
        {cpu_req, cpu_we, dbg_req, dbg_we} = 4'b0000;
        cpu_addr = 8'h00; dbg_addr = 8'h00; cpu_wdata = 32'h0; dbg_wdata = 32'h0;
        {l3_cpu_req, l3_cpu_we, l3_dbg_req, l3_dbg_we} = 4'b0000;
        l3_cpu_addr = 8'h00; l3_dbg_addr = 8'h00; l3_cpu_wdata = 32'h0; l3_dbg_wdata = 32'h0;
        ref_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ack_err", {28'd0, cpu_ack, dbg_ack, cpu_err, dbg_err}, 32'd0);
        chk("rst_mem_busy", {29'd0, mem_en, mem_we, busy}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);

        // 1: CPU load @0x00, expect word 5, ack at t+3
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
        push(0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("t1_stall_t", 32'(cpu_stall), 32'd1);
        chk("t1_men_t", 32'(mem_en), 32'd0);
        @(negedge clk);
        chk("t1_men_t1", 32'(mem_en), 32'd1);
        chk("t1_mwe_t1", 32'(mem_we), 32'd0);
        chk("t1_maddr", 32'(mem_addr), 32'h00);
        chk("t1_stall_t1", 32'(cpu_stall), 32'd1);
        @(negedge clk);
        chk("t1_men_t2", 32'(mem_en), 32'd0);
        chk("t1_ack_t2", 32'(cpu_ack), 32'd0);
        chk("t1_stall_t2", 32'(cpu_stall), 32'd1);
        @(negedge clk);
        chk("t1_ack_t3", 32'(cpu_ack), 32'd1);
        chk("t1_stall_t3", 32'(cpu_stall), 32'd0);
        chk("t1_rdata", cpu_rdata, 32'd5);
        next_cycle();
        cpu_req = 1'b0;

        // 2: simultaneous cpu store 0x11 @0x04 and dbg load @0x04 after reset
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h04; cpu_wdata = 32'h11;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h04;
        push(0, 1'b1, 8'h04, 32'h11);
        push(1, 1'b0, 8'h04, 32'h0);
        wait_ack(0, 20);
        next_cycle();
        cpu_req = 1'b0; cpu_we = 1'b0;
        wait_ack(1, 20);
        next_cycle();
        dbg_req = 1'b0;

        // 3: continuous requests from both ports, six grants alternating
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h0C;
        for (int k = 0; k < 6; k++) push(k % 2, 1'b0, (k % 2 == 0) ? 8'h10 : 8'h0C, 32'h0);
        for (int k = 0; k < 6; k++) wait_ack(k % 2, 20);
        next_cycle();
        cpu_req = 1'b0; dbg_req = 1'b0;

        // 4: dbg boundary load @0x1C, then misaligned @0x06 and out of range @0x20
        dbg_req = 1'b1; dbg_addr = 8'h1C;
        push(1, 1'b0, 8'h1C, 32'h0);
        wait_ack(1, 20);
        next_cycle();
        dbg_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            dbg_req = 1'b1; dbg_addr = (k == 0) ? 8'h06 : 8'h20;
            push(1, 1'b0, dbg_addr, 32'h0);
            @(negedge clk);
            chk("t4_men_t", 32'(mem_en), 32'd0);
            @(negedge clk);
            chk("t4_ack_t1", 32'(dbg_ack), 32'd1);
            chk("t4_err_t1", 32'(dbg_err), 32'd1);
            chk("t4_men_t1", 32'(mem_en), 32'd0);
            next_cycle();
            dbg_req = 1'b0;
        end

        // 5: MEM_LAT=3, cpu load @0x08 -> ack at t+5, single mem_en
        next_cycle();
        l3_cpu_req = 1'b1; l3_cpu_addr = 8'h08;
        en_cnt = 0; en_cyc = -1; ack_cyc = -1;
        for (int c = 0; c < 12 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (l3_mem_en) begin
                en_cnt++;
                en_cyc = c;
            end
            if (l3_cpu_ack) ack_cyc = c;
        end
        chk("t5_ack_cycle", 32'(ack_cyc), 32'd5);
        chk("t5_en_count", 32'(en_cnt), 32'd1);
        chk("t5_en_cycle", 32'(en_cyc), 32'd1);
        chk("t5_rdata", l3_cpu_rdata, init_word(2));
        chk("t5_err", 32'(l3_cpu_err), 32'd0);
        next_cycle();
        l3_cpu_req = 1'b0;

        // 6: reset during WAIT of a dbg load aborts it; next tie goes to the CPU
        next_cycle();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h14;
        @(negedge clk);
        @(negedge clk);
        chk("t6_men_t1", 32'(mem_en), 32'd1);
        next_cycle();
        rst = 1'b1;
        dbg_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        ref_reset();
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_no_ack", 32'(dbg_ack), 32'd0);
        chk("t6_no_men", 32'(mem_en), 32'd0);
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h04;
        push(0, 1'b0, 8'h00, 32'h0);
        push(1, 1'b0, 8'h04, 32'h0);
        wait_ack(0, 20);
        next_cycle();
        cpu_req = 1'b0;
        wait_ack(1, 20);
        next_cycle();
        dbg_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
